// File: rtl/wb_memslave_if.sv
// Pipelined Wishbone bus between the bench master and the wb_memslave RAM model.
// Signal names are given from the slave's point of view:
//   i_wb_cyc/stb/we  bus cycle, request strobe, write enable
//   i_wb_addr        word address (AW bits)
//   i_wb_data        write data (DW bits)
//   i_wb_sel         byte-lane enables (DW/8 bits)
//   o_wb_stall       request not accepted this cycle
//   o_wb_ack/err     one-cycle completion pulses (never together)
//   o_wb_data        read data, valid with o_wb_ack, zero otherwise
interface wb_memslave_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic              i_wb_cyc;
    logic              i_wb_stb;
    logic              i_wb_we;
    logic [AW-1:0]     i_wb_addr;
    logic [DW-1:0]     i_wb_data;
    logic [DW/8-1:0]   i_wb_sel;
    logic              o_wb_stall;
    logic              o_wb_ack;
    logic              o_wb_err;
    logic [DW-1:0]     o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );
endinterface

// File: rtl/wb_memslave.sv
// wb_memslave: bench-side pipelined Wishbone RAM model.
// Accepts requests whenever not stalled, performs byte-lane writes at accept,
// samples read data at accept, and returns ack (or err for the error address)
// exactly LATENCY cycles later through a shift-register pipeline. A 16-bit
// LFSR produces pseudo-random stalls to exercise master flow control.
// Ports:
//   i_clk      clock
//   i_reset    synchronous active-high reset
//   wb         slave side of wb_memslave_if (cyc/stb/we/addr/data/sel in,
//              stall/ack/err/data out)
//   o_nreads   reads acknowledged since reset (wraps)
//   o_nwrites  writes acknowledged since reset (wraps)
module wb_memslave #(
    parameter int              AW         = 5,
    parameter int              DW         = 32,
    parameter int              LATENCY    = 2,
    parameter logic            OPT_STALL  = 1'b1,
    parameter logic [15:0]     STALL_SEED = 16'hACE1,
    parameter logic            OPT_ERR    = 1'b0,
    parameter logic [AW-1:0]   ERR_ADDR   = {AW{1'b1}}
) (
    input  logic               i_clk,
    input  logic               i_reset,
    wb_memslave_if.slave       wb,
    output logic [31:0]        o_nreads,
    output logic [31:0]        o_nwrites
);
    localparam int SW = DW / 8;
    localparam int MD = 1 << AW;

    logic [DW-1:0]        r_mem [MD];
    logic [15:0]          r_lfsr;
    logic                 w_fb;
    logic                 w_stall;
    logic                 w_accept;
    logic                 w_is_err;
    logic                 w_flush;

    // Pipeline stage k holds a completion that is k+1 edges old; the last
    // stage drives the bus outputs directly so they are registered.
    logic [LATENCY-1:0]   r_pack;
    logic [LATENCY-1:0]   r_perr;
    logic [LATENCY-1:0]   r_pwe;
    logic [DW-1:0]        r_pdata [LATENCY];
    logic [LATENCY-1:0]   w_nack;
    logic [LATENCY-1:0]   w_nerr;
    logic [LATENCY-1:0]   w_nwe;
    logic [DW-1:0]        w_ndata [LATENCY];

    logic [31:0]          r_nreads;
    logic [31:0]          r_nwrites;

    // Fibonacci feedback for taps 16,14,13,11; stall depends on state only.
    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_stall  = OPT_STALL && (r_lfsr[1:0] == 2'b00);
    assign w_accept = wb.i_wb_cyc && wb.i_wb_stb && !w_stall && !i_reset;
    assign w_is_err = OPT_ERR && (wb.i_wb_addr == ERR_ADDR);

    // Next pipeline contents: load, shift, error flush, cycle abort, data gating.
    always_comb begin
        w_nack = {LATENCY{1'b0}};
        w_nerr = {LATENCY{1'b0}};
        w_nwe  = {LATENCY{1'b0}};
        for (int k = 0; k < LATENCY; k++) begin
            w_ndata[k] = {DW{1'b0}};
        end
        w_nack[0]  = w_accept && !w_is_err;
        w_nerr[0]  = w_accept && w_is_err;
        w_nwe[0]   = wb.i_wb_we;
        w_ndata[0] = (wb.i_wb_we || w_is_err) ? {DW{1'b0}} : r_mem[wb.i_wb_addr];
        for (int k = 1; k < LATENCY; k++) begin
            w_nack[k]  = r_pack[k-1];
            w_nerr[k]  = r_perr[k-1];
            w_nwe[k]   = r_pwe[k-1];
            w_ndata[k] = r_pdata[k-1];
        end
        // An error reaching the output drops everything issued after it.
        w_flush = w_nerr[LATENCY-1];
        for (int k = 0; k < LATENCY - 1; k++) begin
            w_nack[k] = w_nack[k] && !w_flush;
            w_nerr[k] = w_nerr[k] && !w_flush;
        end
        // Dropping cyc abandons every outstanding request.
        w_nack = w_nack & {LATENCY{wb.i_wb_cyc}};
        w_nerr = w_nerr & {LATENCY{wb.i_wb_cyc}};
        // Data lines carry only read data of live acks, zero otherwise.
        for (int k = 0; k < LATENCY; k++) begin
            w_ndata[k] = w_nack[k] ? w_ndata[k] : {DW{1'b0}};
        end
    end

    // LFSR, pipeline registers and completion counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr    <= STALL_SEED;
            r_pack    <= {LATENCY{1'b0}};
            r_perr    <= {LATENCY{1'b0}};
            r_pwe     <= {LATENCY{1'b0}};
            for (int k = 0; k < LATENCY; k++) begin
                r_pdata[k] <= {DW{1'b0}};
            end
            r_nreads  <= 32'd0;
            r_nwrites <= 32'd0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            r_pack <= w_nack;
            r_perr <= w_nerr;
            r_pwe  <= w_nwe;
            for (int k = 0; k < LATENCY; k++) begin
                r_pdata[k] <= w_ndata[k];
            end
            // Counted on the edge that closes the ack cycle.
            if (r_pack[LATENCY-1]) begin
                if (r_pwe[LATENCY-1]) begin
                    r_nwrites <= r_nwrites + 32'd1;
                end else begin
                    r_nreads  <= r_nreads + 32'd1;
                end
            end
        end
    end

    // Byte-lane write at accept; error-address writes never reach the array.
    always_ff @(posedge i_clk) begin
        if (w_accept && wb.i_wb_we && !w_is_err) begin
            for (int k = 0; k < SW; k++) begin
                if (wb.i_wb_sel[k]) begin
                    r_mem[wb.i_wb_addr][k*8 +: 8] <= wb.i_wb_data[k*8 +: 8];
                end
            end
        end
    end

    assign wb.o_wb_stall = w_stall;
    assign wb.o_wb_ack   = r_pack[LATENCY-1];
    assign wb.o_wb_err   = r_perr[LATENCY-1];
    assign wb.o_wb_data  = r_pdata[LATENCY-1];
    assign o_nreads      = r_nreads;
    assign o_nwrites     = r_nwrites;
endmodule

// File: tb/tb_wb_memslave.sv
// Self-checking bench for wb_memslave. Three instances cover the configurations:
//   dut_a: LATENCY=2, no stall, OPT_ERR with ERR_ADDR=0x1F
//   dut_b: LATENCY=2, pseudo-random stall
//   dut_c: LATENCY=4, no stall, with a private reset for mid-burst reset
// A shared master drives whichever instance dsel selects; expected completions
// are queued at accept and compared when ack/err appears.
module tb_wb_memslave;
    logic        clk = 1'b0;
    logic        tb_rst;
    logic        tb_rst_c;
    logic        tb_cyc;
    logic        tb_stb;
    logic        tb_we;
    logic [4:0]  tb_addr;
    logic [31:0] tb_data;
    logic [3:0]  tb_sel;
    int          dsel;

    logic        w_stall, w_ack, w_err;
    logic [31:0] w_rdata, w_nreads, w_nwrites;
    logic [31:0] nr_a, nw_a, nr_b, nw_b, nr_c, nw_c;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model [3][32];
    int          lat_of [3];
    int          exp_nr [3];
    int          exp_nw [3];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_cnt = 0;
    int          n_acc = 0;
    int          n_done = 0;

    always #5 clk = ~clk;

    wb_memslave_if #(.AW(5), .DW(32)) bus_a ();
    wb_memslave_if #(.AW(5), .DW(32)) bus_b ();
    wb_memslave_if #(.AW(5), .DW(32)) bus_c ();

    assign bus_a.i_wb_cyc = tb_cyc && (dsel == 0);
    assign bus_b.i_wb_cyc = tb_cyc && (dsel == 1);
    assign bus_c.i_wb_cyc = tb_cyc && (dsel == 2);
    assign bus_a.i_wb_stb = tb_stb;  assign bus_b.i_wb_stb = tb_stb;  assign bus_c.i_wb_stb = tb_stb;
    assign bus_a.i_wb_we  = tb_we;   assign bus_b.i_wb_we  = tb_we;   assign bus_c.i_wb_we  = tb_we;
    assign bus_a.i_wb_addr = tb_addr; assign bus_b.i_wb_addr = tb_addr; assign bus_c.i_wb_addr = tb_addr;
    assign bus_a.i_wb_data = tb_data; assign bus_b.i_wb_data = tb_data; assign bus_c.i_wb_data = tb_data;
    assign bus_a.i_wb_sel = tb_sel;  assign bus_b.i_wb_sel = tb_sel;  assign bus_c.i_wb_sel = tb_sel;

    wb_memslave #(.AW(5), .DW(32), .LATENCY(2), .OPT_STALL(1'b0), .STALL_SEED(16'hACE1),
                  .OPT_ERR(1'b1), .ERR_ADDR(5'h1F))
        dut_a (.i_clk(clk), .i_reset(tb_rst), .wb(bus_a), .o_nreads(nr_a), .o_nwrites(nw_a));
    wb_memslave #(.AW(5), .DW(32), .LATENCY(2), .OPT_STALL(1'b1), .STALL_SEED(16'hACE1),
                  .OPT_ERR(1'b0), .ERR_ADDR(5'h1F))
        dut_b (.i_clk(clk), .i_reset(tb_rst), .wb(bus_b), .o_nreads(nr_b), .o_nwrites(nw_b));
    wb_memslave #(.AW(5), .DW(32), .LATENCY(4), .OPT_STALL(1'b0), .STALL_SEED(16'hACE1),
                  .OPT_ERR(1'b0), .ERR_ADDR(5'h1F))
        dut_c (.i_clk(clk), .i_reset(tb_rst || tb_rst_c), .wb(bus_c), .o_nreads(nr_c), .o_nwrites(nw_c));

    // Route the selected instance's outputs to the common monitor.
    always_comb begin
        case (dsel)
            0: begin
                w_stall = bus_a.o_wb_stall; w_ack = bus_a.o_wb_ack; w_err = bus_a.o_wb_err;
                w_rdata = bus_a.o_wb_data;  w_nreads = nr_a; w_nwrites = nw_a;
            end
            1: begin
                w_stall = bus_b.o_wb_stall; w_ack = bus_b.o_wb_ack; w_err = bus_b.o_wb_err;
                w_rdata = bus_b.o_wb_data;  w_nreads = nr_b; w_nwrites = nw_b;
            end
            default: begin
                w_stall = bus_c.o_wb_stall; w_ack = bus_c.o_wb_ack; w_err = bus_c.o_wb_err;
                w_rdata = bus_c.o_wb_data;  w_nreads = nr_c; w_nwrites = nw_c;
            end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edge counter; at the falling edge after rising edge N it reads N.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Completion monitor: pop and compare on every ack/err.
    always @(negedge clk) begin
        if (!tb_rst) begin
            check_val("ack_err_excl", {31'd0, w_ack & w_err}, 32'd0);
            if (w_ack || w_err) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    check_val("spurious_completion", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("completion_kind_err", {31'd0, w_err}, {31'd0, mon_e.err});
                    check_val("completion_cycle", cyc_cnt, mon_e.due);
                    if (w_ack && mon_e.rd) check_val("read_data", w_rdata, mon_e.data);
                end
            end else begin
                check_val("idle_data_zero", w_rdata, 32'd0);
            end
        end
    end

    // Present one request, hold it through stalls, record the expectation at accept.
    task automatic wb_req(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic st;
        logic er;
        int   tries;
        exp_t e;
        tb_cyc = 1'b1; tb_stb = 1'b1; tb_we = we; tb_addr = a; tb_data = d; tb_sel = s;
        tries = 0;
        forever begin
            st = w_stall;
            @(negedge clk);
            if (!st) break;
            tries++;
            if (tries > 64) begin
                check_val("stall_timeout", 32'd1, 32'd0);
                break;
            end
        end
        er     = (dsel == 0) && (a == 5'h1F);
        e.err  = er;
        e.rd   = !we;
        e.data = we ? 32'd0 : model[dsel][a];
        e.due  = cyc_cnt + lat_of[dsel] - 1;
        if (!er) begin
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (s[k]) model[dsel][a][k*8 +: 8] = d[k*8 +: 8];
                end
                exp_nw[dsel]++;
            end else begin
                exp_nr[dsel]++;
            end
        end
        n_acc++;
        sb_q.push_back(e);
    endtask

    // Let outstanding completions arrive, then close the bus cycle.
    task automatic drain();
        tb_stb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            check_val("drain_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
        tb_cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_nreads"}, w_nreads, exp_nr[dsel]);
        check_val({tag, "_nwrites"}, w_nwrites, exp_nw[dsel]);
    endtask

    initial begin
        int d0;
        lat_of[0] = 2; lat_of[1] = 2; lat_of[2] = 4;
        for (int d = 0; d < 3; d++) begin
            exp_nr[d] = 0; exp_nw[d] = 0;
            for (int a = 0; a < 32; a++) model[d][a] = 32'd0;
        end
        tb_rst = 1'b1; tb_rst_c = 1'b0; tb_cyc = 1'b0; tb_stb = 1'b0; tb_we = 1'b0;
        tb_addr = 5'd0; tb_data = 32'd0; tb_sel = 4'h0; dsel = 0;
        repeat (3) @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);

        // Reset state of every instance.
        for (int d = 0; d < 3; d++) begin
            dsel = d;
            #1;
            check_val("rst_ack", {31'd0, w_ack}, 32'd0);
            check_val("rst_err", {31'd0, w_err}, 32'd0);
            check_val("rst_data", w_rdata, 32'd0);
            check_val("rst_nreads", w_nreads, 32'd0);
            check_val("rst_nwrites", w_nwrites, 32'd0);
        end
        dsel = 0;
        @(negedge clk);

        // Single write then read with fixed latency.
        wb_req(1'b1, 5'h04, 32'hDEADBEEF, 4'hF);
        wb_req(1'b0, 5'h04, 32'h0, 4'hF);
        drain();
        check_counts("t1");

        // Partial byte-lane write merge.
        wb_req(1'b1, 5'h03, 32'h11223344, 4'hF);
        wb_req(1'b1, 5'h03, 32'hAABBCCDD, 4'b0010);
        wb_req(1'b0, 5'h03, 32'h0, 4'hF);
        drain();
        check_val("t2_model_merge", model[0][3], 32'h1122CC44);

        // Fill then eight back-to-back reads.
        for (int i = 0; i < 8; i++) wb_req(1'b1, 5'(i), 32'h100 + 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) wb_req(1'b0, 5'(i), 32'h0, 4'hF);
        drain();
        check_counts("t3");

        // Error address: err instead of ack, no write, counters untouched.
        wb_req(1'b1, 5'h1F, 32'h5, 4'hF);
        drain();
        wb_req(1'b0, 5'h1F, 32'h0, 4'hF);
        drain();
        check_counts("t5");

        // Pseudo-random stalls on 16 writes and 16 reads.
        dsel = 1;
        d0 = n_done;
        @(negedge clk);
        for (int i = 0; i < 16; i++) wb_req(1'b1, 5'(i + 8), $urandom, 4'hF);
        for (int i = 0; i < 16; i++) wb_req(1'b0, 5'(i + 8), 32'h0, 4'hF);
        drain();
        check_val("t4_completions", n_done - d0, 32'd32);
        check_counts("t4");

        // LATENCY=4: cycle abort drops outstanding reads.
        dsel = 2;
        @(negedge clk);
        wb_req(1'b1, 5'h00, 32'hCAFE0001, 4'hF);
        wb_req(1'b0, 5'h00, 32'h0, 4'hF);
        drain();
        check_counts("t6_pre");
        for (int i = 0; i < 3; i++) wb_req(1'b0, 5'(i), 32'h0, 4'hF);
        tb_cyc = 1'b0; tb_stb = 1'b0;
        exp_nr[2] = exp_nr[2] - 3;
        sb_q.delete();
        repeat (10) @(negedge clk);
        check_counts("t6_abort");

        // Reset mid-burst drops everything and clears counters.
        for (int i = 0; i < 3; i++) wb_req(1'b0, 5'(i), 32'h0, 4'hF);
        tb_stb = 1'b0;
        tb_rst_c = 1'b1;
        sb_q.delete();
        exp_nr[2] = 0; exp_nw[2] = 0;
        @(negedge clk);
        tb_rst_c = 1'b0;
        repeat (10) @(negedge clk);
        tb_cyc = 1'b0;
        @(negedge clk);
        check_counts("t6_reset");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
